// File: rtl/seqmul_mac.sv
// rtl/seqmul_mac.sv - sequential shift-add multiplier with signed mode, accumulate and early termination
module seqmul_mac #(
    parameter int WIDTH      = 4,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               sgn,
    input  logic               acc,
    output logic [2*WIDTH-1:0] res,
    output logic               done,
    output logic               busy
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [RW-1:0]   prod_q, prod_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            acc_l_q, acc_l_d;
    logic [RW-1:0]   res_q, res_d;
    logic            done_q, done_d;

    // Operands are multiplied as magnitudes; the sign is reapplied at the end.
    logic [WIDTH-1:0] mag_a, mag_b;
    assign mag_a = (sgn && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
    assign mag_b = (sgn && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            acc_l_q  <= 1'b0;
            res_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            acc_l_q  <= acc_l_d;
            res_q    <= res_d;
            done_q   <= done_d;
        end
    end

    logic [WIDTH-1:0] mplier_shift;
    logic [RW-1:0]    prod_signed;

    // Next-state logic: latch operands in IDLE, one multiplier bit per RUN cycle, write result in FINISH.
    always_comb begin
        state_d      = state_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        prod_d       = prod_q;
        cnt_d        = cnt_q;
        neg_d        = neg_q;
        acc_l_d      = acc_l_q;
        res_d        = res_q;
        done_d       = 1'b0;
        mplier_shift = mplier_q >> 1;
        prod_signed  = neg_q ? (~prod_q + RW'(1)) : prod_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = RW'(mag_a);
                    mplier_d = mag_b;
                    prod_d   = '0;
                    cnt_d    = '0;
                    neg_d    = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_l_d  = acc;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + CW'(1);
                // Early exit once no set multiplier bits remain; the first RUN cycle always runs.
                if ((cnt_q == CNT_LAST) || (EARLY_TERM && (mplier_shift == '0))) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                res_d   = prod_signed + (acc_l_q ? res_q : '0);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign res  = res_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: doc/seqmul_mac.md
Name: seqmul_mac

Overview:
Parametrised sequential shift-add multiplier for the multiplier peripheral. It processes one multiplier bit per clock and supports signed or unsigned operands per operation. It can optionally accumulate the new product into the previous result (MAC mode), and can terminate early when the remaining multiplier bits are zero. It sits behind the peripheral's register interface, and the host polls busy/done.

Parameters:
WIDTH, 4, operand width in bits; result is 2*WIDTH bits.
EARLY_TERM, 1, 1 = stop iterating once remaining multiplier magnitude bits are all zero; 0 = always WIDTH iterations.

Ports:
clk  input  1  clock; all state changes on posedge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request; A, B, sgn, acc sampled when start=1 and state=IDLE.
A  input  WIDTH  multiplicand.
B  input  WIDTH  multiplier.
sgn  input  1  1 = A and B are two's complement; 0 = unsigned.
acc  input  1  1 = result = product + current res; 0 = result = product.
res  output  2*WIDTH  result register; holds value until next FINISH or reset.
done  output  1  high for exactly one cycle after res is updated.
busy  output  1  high while state is RUN or FINISH.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; res=0, done=0, busy=0; all internal registers cleared. Reset mid-operation aborts it; no done pulse; res=0.
- States: IDLE, RUN, FINISH.
- IDLE, start=1 at edge e0:
  - Latch magA = (sgn & A[msb]) ? -A : A as WIDTH-bit unsigned; same for magB.
  - neg = sgn & (A[msb] ^ B[msb]); acc_l = acc.
  - mcand (2*WIDTH) = zero-extended magA; mplier (WIDTH) = magB; prod = 0; cnt = 0.
  - Go to RUN; busy=1 from e0.
- RUN, each edge:
  - If mplier[0], prod <= prod + mcand (mod 2^(2W)).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - Go to FINISH when cnt == WIDTH-1 (pre-increment), or when EARLY_TERM=1 and the shifted mplier == 0.
  - At least one RUN cycle always executes.
- FINISH, one edge:
  - res <= (neg ? -prod : prod) + (acc_l ? res : 0), mod 2^(2W).
  - done <= 1; busy <= 0; state <= IDLE.
- done clears at the next edge unconditionally.
- Latency: let n = number of RUN cycles.
  - EARLY_TERM=0: n = WIDTH.
  - EARLY_TERM=1: n = max(1, index of highest set bit of magB + 1).
  - res and done are valid after edge e(n+1); done is low again after e(n+2).
- start while busy=1: ignored; operands unchanged; no queuing.
- start in the cycle done=1 (state IDLE): accepted normally. acc=1 then uses the just-written res.
- Signed edge: magnitude of the most negative value (e.g. -8 for WIDTH=4) is 2^(WIDTH-1) and fits unsigned. Full product magnitude ≤ 2^(2W-2) fits 2*WIDTH bits; no overflow except in accumulate, which wraps silently.
- A=0 or B=0: result 0 (or unchanged res with acc=1); sign ignored.

Test Plan:
- WIDTH=4, EARLY_TERM=0, unsigned 15*15, start at e0 -> busy high e0..e5, res=0xE1 (225) and done=1 after e5, done=0 after e6.
- WIDTH=4, EARLY_TERM=1, unsigned 7*1 -> n=1, res=0x07 with done after e2; B=0 -> res=0x00, done after e2.
- Signed: WIDTH=4, A=-8 (0x8), B=7 -> res=0xC8 (-56). A=-8, B=-8 -> res=0x40 (64). A=-1, B=3 -> res=0xFD.
- Accumulate: res=225 from prior op, then 3*3 unsigned with acc=1 -> res=0xEA (234). Then 15*15 with acc=1 -> res=0x1CB mod 256 = 0xCB (wrap).
- start pulsed at e2 with A=1, B=1 during a 5*5 op -> ignored, res=0x19, single done pulse. Back-to-back start during the done cycle -> second op accepted; results correct in order.
- rst_n low mid-RUN (after e2) -> immediately res=0, busy=0, done=0. No done pulse after release; a new start works normally.
